// File: rtl/system_button_ctrl.sv
// system_button_ctrl
// Avalon-MM slave front end for the front-panel push-buttons (active-low).
// Each raw line is synchronised and then debounced. A debounced falling edge
// is a press. Presses are latched in a write-1-to-clear capture register,
// raise a maskable level interrupt, and are queued as press masks in a small
// event FIFO that firmware drains through address 2.
//
// Ports:
//   clk         system clock, all state on its rising edge
//   reset       synchronous, active-high
//   address     register select (0 level, 1 irq mask, 2 FIFO, 3 capture)
//   chipselect  slave select
//   read_n      active-low read strobe (readdata valid one cycle later)
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data
//   in_port     raw button inputs, asynchronous, active-low
//   irq         level interrupt, active-high
module system_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] press;

  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic             overflow;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;

  logic             rd_en;
  logic             wr_en;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign rd_en      = chipselect & ~read_n;
  assign wr_en      = chipselect & ~write_n;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push_req   = |press;
  assign do_pop     = rd_en & (address == 2'd2) & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_req & (~fifo_full | do_pop);
  assign ovf_set    = push_req & fifo_full & ~do_pop;
  assign unused_bits = ^{writedata[31:10], writedata[8:WIDTH]};

  // ---- stage: synchroniser and per-bit debounce ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '1;
      s2       <= '1;
      stable   <= '1;
      stable_d <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced falling edge; stable is active-low so 1->0 is a press.
  assign press = stable_d & ~stable;

  // ---- stage: capture, mask, overflow and FIFO control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      // Clear is applied after the set so a simultaneous W1C wins.
      if (wr_en && address == 2'd3)
        edge_capture <= (edge_capture | press) & ~writedata[WIDTH-1:0];
      else
        edge_capture <= edge_capture | press;

      if (wr_en && address == 2'd1)
        irq_mask <= writedata[WIDTH-1:0];

      // A fresh overflow outranks a clear arriving on the same edge.
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_en && address == 2'd2 && writedata[9])
        overflow <= 1'b0;

      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= press;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[WIDTH-1:0] = stable;
      2'd1: rd_mux[WIDTH-1:0] = irq_mask;
      2'd2: begin
        if (!fifo_empty) rd_mux[WIDTH-1:0] = mem[rd_ptr];
        rd_mux[8]       = ~fifo_empty;
        rd_mux[9]       = overflow;
        rd_mux[16 +: CW] = count;
      end
      default: rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // ---- stage: registered read data ----
  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (rd_en)
      readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
